// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard detection and pipeline steering for the
// 5-stage MIPS core. It compares the sources of the instruction in IF/ID
// against the destination of the instruction in ID/EX. When it finds a
// dependency it stalls the front end and turns the decoded controls into a
// bubble. When a branch is taken or a jump is decoded it flushes IF/ID.
//
// Handshake/steering semantics, in one place:
//   stall cycle     : pc_write=0, if_id_write=0, control_mux=0, if_id_flush=0
//   non-stall cycle : pc_write=1, if_id_write=1, control_mux=1,
//                     if_id_flush = branch_taken | jump
//   Stall wins over flush. During a stall the branch comparison and the
//   decode are not valid yet, so branch_taken and jump are ignored.
//   While reset is high every control output is 0.
//
// Only the FSM state and the two performance counters are registered. The
// control outputs are decoded from the state and the inputs alone, so the
// counters never feed back into the steering logic.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_instr,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_reg_write,
  input  logic [4:0]       id_ex_write_reg,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             control_mux,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // RUN : normal hazard checking.
  // HOLD: second stall cycle of a load feeding an ID-stage branch. The
  //       load data only reaches the comparator one cycle later.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Instruction fields.
  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;

  // Decode results.
  logic rs_used;
  logic rt_used;
  logic is_branch;
  logic rs_match;
  logic rt_match;
  logic dep;

  // Hazard classes, evaluated in RUN.
  logic load_use;
  logic alu_branch;
  logic load_branch;

  // Cycle classification.
  logic stall;
  logic flush;

  // Immediate/shamt/rd bits are not needed for source decoding.
  logic unused_instr_bits;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign funct  = if_id_instr[5:0];

  assign unused_instr_bits = ^if_id_instr[15:6];

  // Work out which source fields the ID instruction really reads.
  always_comb begin
    rs_used   = 1'b1;
    rt_used   = 1'b0;
    is_branch = 1'b0;

    // j / jal hold a jump target in the rs field, not a register.
    if (opcode == 6'h02 || opcode == 6'h03) begin
      rs_used = 1'b0;
    end

    // sll / srl / sra shift rt by shamt, so rs is unused.
    if (opcode == 6'h00 &&
        (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)) begin
      rs_used = 1'b0;
    end

    // rt is a source for R-type, beq, bne and sw. For other I-types it is
    // the destination.
    if (opcode == 6'h00 || opcode == 6'h04 ||
        opcode == 6'h05 || opcode == 6'h2B) begin
      rt_used = 1'b1;
    end

    if (opcode == 6'h04 || opcode == 6'h05) begin
      is_branch = 1'b1;
    end
  end

  // $0 is hardwired to zero, so a write to it can never create a dependency.
  assign rs_match = rs_used && (rs == id_ex_write_reg);
  assign rt_match = rt_used && (rt == id_ex_write_reg);
  assign dep      = id_ex_reg_write && (id_ex_write_reg != 5'd0) &&
                    (rs_match || rt_match);

  assign load_use    = dep && id_ex_mem_read;
  assign alu_branch  = dep && is_branch && !id_ex_mem_read;
  assign load_branch = dep && is_branch && id_ex_mem_read;

  // Next-state logic and stall/flush classification for the current cycle.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    flush      = 1'b0;

    case (state)
      RUN: begin
        if (load_use || alu_branch) begin
          stall = 1'b1;
        end
        if (load_branch) begin
          state_next = HOLD;
        end
        if (!stall) begin
          flush = branch_taken | jump;
        end
      end

      HOLD: begin
        // Unconditional stall. Hazard inputs are stale here, so ignore them.
        stall      = 1'b1;
        state_next = RUN;
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Drive the control outputs. While reset is high, everything is held off.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    control_mux = 1'b0;

    if (!reset) begin
      pc_write    = !stall;
      if_id_write = !stall;
      control_mux = !stall;
      if_id_flush = flush;
    end
  end

  // State register. Reset returns to RUN at once, even from HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Saturating count of cycles in which IF/ID was flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count <= '0;
    end else if (if_id_flush && (flush_count != {CNT_W{1'b1}})) begin
      flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
